// File: rtl/mac_stream.sv
// rtl/mac_stream.sv - pipelined multiply-accumulate over valid/last framed operand streams
//
// Purpose: computes one dot product per frame of operand pairs. Stage P
// registers the product of each accepted pair; stage A adds it to the running
// accumulator. On the last pair of a frame the sum is emitted with a
// one-cycle out_valid pulse and a sticky overflow flag.
//
// Optional feature: define MAC_SATURATE_EN to clamp the sum on overflow.
// When it is undefined the sum wraps modulo 2^ACC_W. Overflow is reported
// in both builds.
//
// Parameters:
//   DATA_W  operand width (2..32)
//   ACC_W   accumulator/result width (>= 2*DATA_W)
//   SIGNED  0 = unsigned operands, 1 = two's-complement operands
//
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   in_valid  a/b/in_last valid this cycle
//   in_last   final pair of a frame
//   a, b      operands (DATA_W)
//   acc       running accumulator of the current frame (ACC_W)
//   out_valid one-cycle pulse when a frame completes
//   out_data  completed frame sum, held until the next frame completes
//   out_ovf   frame overflowed ACC_W at some step, held with out_data

module mac_stream #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);

    localparam int P_W = 2 * DATA_W;

    logic [P_W-1:0]   r_p;
    logic             r_p_valid;
    logic             r_p_last;
    logic [ACC_W-1:0] r_acc;
    logic             r_first;
    logic             r_ovf_sticky;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_data;
    logic             r_out_ovf;

    logic [P_W-1:0]   w_a_x;
    logic [P_W-1:0]   w_b_x;
    logic [P_W-1:0]   w_prod;
    logic [ACC_W-1:0] w_p_ext;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W:0]   w_sum_full;
    logic [ACC_W-1:0] w_raw;
    logic             w_ovf;
    logic [ACC_W-1:0] w_sum;

    // Operands are extended to the product width first, so the low P_W bits
    // of the product are correct for both signed and unsigned operation.
    always_comb begin
        w_a_x  = {{DATA_W{(SIGNED != 0) && a[DATA_W-1]}}, a};
        w_b_x  = {{DATA_W{(SIGNED != 0) && b[DATA_W-1]}}, b};
        w_prod = w_a_x * w_b_x;
    end

    always_comb begin
        w_p_ext = '0;
        w_p_ext[P_W-1:0] = r_p;
        for (int i = P_W; i < ACC_W; i++) begin
            w_p_ext[i] = (SIGNED != 0) && r_p[P_W-1];
        end
    end

    // A frame's first product starts from zero rather than the held acc.
    assign w_base     = r_first ? '0 : r_acc;
    assign w_sum_full = {1'b0, w_base} + {1'b0, w_p_ext};
    assign w_raw      = w_sum_full[ACC_W-1:0];

    always_comb begin
        if (SIGNED != 0) begin
            w_ovf = (w_base[ACC_W-1] == w_p_ext[ACC_W-1]) &&
                    (w_raw[ACC_W-1] != w_base[ACC_W-1]);
        end else begin
            w_ovf = w_sum_full[ACC_W];
        end
    end

`ifdef MAC_SATURATE_EN
    // Signed overflow only happens with equal operand signs, so the sign of
    // the base selects which rail to clamp to.
    always_comb begin
        w_sum = w_raw;
        if (w_ovf) begin
            if (SIGNED == 0) begin
                w_sum = '1;
            end else if (w_base[ACC_W-1]) begin
                w_sum = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                w_sum = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end
`else
    assign w_sum = w_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p          <= '0;
            r_p_valid    <= 1'b0;
            r_p_last     <= 1'b0;
            r_acc        <= '0;
            r_first      <= 1'b1;
            r_ovf_sticky <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ovf    <= 1'b0;
        end else begin
            r_p_valid   <= in_valid;
            r_p_last    <= in_valid && in_last;
            r_out_valid <= 1'b0;
            if (in_valid) begin
                r_p <= w_prod;
            end
            if (r_p_valid) begin
                if (r_p_last) begin
                    r_out_data   <= w_sum;
                    r_out_ovf    <= r_ovf_sticky | w_ovf;
                    r_out_valid  <= 1'b1;
                    r_acc        <= '0;
                    r_ovf_sticky <= 1'b0;
                    r_first      <= 1'b1;
                end else begin
                    r_acc        <= w_sum;
                    r_ovf_sticky <= r_ovf_sticky | w_ovf;
                    r_first      <= 1'b0;
                end
            end
        end
    end

    assign acc       = r_acc;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule
